// File: rtl/gray_decoder.sv
// Gray-code bus receiver: decodes each strobed sample to binary and checks that
// successive samples form a legal +1/hold sequence, flagging wraps and step errors.
module gray_decoder #(
   parameter int WIDTH     = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     gray,
   output logic [WIDTH-1:0]     binary,
   output logic                 wrap,
   output logic                 locked,
   output logic                 error,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] dec;
   logic [WIDTH-1:0] nxt;
   logic             is_hold;
   logic             is_step;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Error counter holds at all-ones instead of rolling over.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      if (c == '1) begin
         return c;
      end
      return c + ERR_CNT_W'(1);
   endfunction

   assign dec     = gray2bin(gray);
   assign nxt     = prev + WIDTH'(1);
   assign is_hold = (dec == prev);
   assign is_step = (dec == nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         prev    <= '0;
         binary  <= '0;
         wrap    <= 1'b0;
         locked  <= 1'b0;
         error   <= 1'b0;
         err_cnt <= '0;
      end else begin
         wrap <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            prev    <= '0;
            binary  <= '0;
            locked  <= 1'b0;
            error   <= 1'b0;
            err_cnt <= '0;
         end else if (en) begin
            case (state)
               IDLE: begin
                  prev   <= dec;
                  binary <= dec;
                  state  <= ACQ;
               end
               ACQ: begin
                  prev   <= dec;
                  binary <= dec;
                  if (is_step) begin
                     state  <= LOCK;
                     locked <= 1'b1;
                  end
               end
               LOCK: begin
                  // A hold leaves everything untouched; only steps and faults move state.
                  if (is_step) begin
                     prev   <= dec;
                     binary <= dec;
                     wrap   <= (prev == '1) && (dec == '0);
                  end else if (!is_hold) begin
                     prev    <= dec;
                     binary  <= dec;
                     error   <= 1'b1;
                     err_cnt <= sat_inc(err_cnt);
                     locked  <= 1'b0;
                     state   <= ACQ;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: a behavioural model feeds a scoreboard queue, plus
// per-scenario tasks with their own directed expectations.
module tb_gray_decoder;

   localparam int WIDTH     = 3;
   localparam int ERR_CNT_W = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 en;
   logic                 clear;
   logic [WIDTH-1:0]     gray;
   logic [WIDTH-1:0]     binary;
   logic                 wrap;
   logic                 locked;
   logic                 error;
   logic [ERR_CNT_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;

   gray_decoder #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .clear  (clear),
      .gray   (gray),
      .binary (binary),
      .wrap   (wrap),
      .locked (locked),
      .error  (error),
      .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0]     bin;
      logic                 wrap;
      logic                 locked;
      logic                 error;
      logic [ERR_CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state (0=idle, 1=acquire, 2=locked)
   int                   m_st = 0;
   logic [WIDTH-1:0]     m_prev = '0;
   logic [WIDTH-1:0]     m_bin = '0;
   logic                 m_wrap = 1'b0;
   logic                 m_locked = 1'b0;
   logic                 m_err = 1'b0;
   logic [ERR_CNT_W-1:0] m_cnt = '0;

   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_st = 0; m_prev = '0; m_bin = '0; m_wrap = 1'b0;
      m_locked = 1'b0; m_err = 1'b0; m_cnt = '0;
   endtask

   task automatic model_step(input logic e, input logic c, input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] nx;
      d  = g2b(g);
      nx = m_prev + 3'd1;
      m_wrap = 1'b0;
      if (!rst_n || c) begin
         model_reset();
      end else if (e) begin
         if (m_st == 0) begin
            m_prev = d; m_bin = d; m_st = 1;
         end else if (m_st == 1) begin
            if (d == nx) begin m_st = 2; m_locked = 1'b1; end
            m_prev = d; m_bin = d;
         end else if (d != m_prev) begin
            if (d == nx) begin
               m_wrap = (d == '0);
            end else begin
               m_err = 1'b1;
               if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
               m_locked = 1'b0;
               m_st = 1;
            end
            m_prev = d; m_bin = d;
         end
      end
   endtask

   // Drive on the falling edge, push the model's prediction, then settle past the rising edge.
   task automatic cycle(input logic e, input logic c, input logic [WIDTH-1:0] g);
      exp_t x;
      @(negedge clk);
      en = e; clear = c; gray = g;
      model_step(e, c, g);
      x.bin = m_bin; x.wrap = m_wrap; x.locked = m_locked; x.error = m_err; x.cnt = m_cnt;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: one prediction per rising edge once stimulus starts.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb_q.size() > 0) begin
         x = sb_q.pop_front();
         checks++;
         if (binary !== x.bin) begin
            errors++; $display("FAIL sb_binary got %0d exp %0d at %0t", binary, x.bin, $time);
         end
         checks++;
         if (wrap !== x.wrap) begin
            errors++; $display("FAIL sb_wrap got %0b exp %0b at %0t", wrap, x.wrap, $time);
         end
         checks++;
         if (locked !== x.locked) begin
            errors++; $display("FAIL sb_locked got %0b exp %0b at %0t", locked, x.locked, $time);
         end
         checks++;
         if (error !== x.error) begin
            errors++; $display("FAIL sb_error got %0b exp %0b at %0t", error, x.error, $time);
         end
         checks++;
         if (err_cnt !== x.cnt) begin
            errors++; $display("FAIL sb_err_cnt got %0d exp %0d at %0t", err_cnt, x.cnt, $time);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; gray = '0;
      #12;
      checks++;
      if ({binary, wrap, locked, error, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got bin=%0d wrap=%0b lock=%0b err=%0b cnt=%0d exp all 0",
                  binary, wrap, locked, error, err_cnt);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_count_sequence();
      logic [WIDTH-1:0] seq [9];
      seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, 1'b0, seq[i]);
         checks++;
         if (binary !== 3'(i % 8)) begin
            errors++; $display("FAIL seq_binary[%0d] got %0d exp %0d", i, binary, i % 8);
         end
         checks++;
         if (locked !== (i >= 1)) begin
            errors++; $display("FAIL seq_locked[%0d] got %0b exp %0b", i, locked, (i >= 1));
         end
         checks++;
         if (wrap !== (i == 8)) begin
            errors++; $display("FAIL seq_wrap[%0d] got %0b exp %0b", i, wrap, (i == 8));
         end
         checks++;
         if (error !== 1'b0) begin
            errors++; $display("FAIL seq_error[%0d] got %0b exp 0", i, error);
         end
      end
      cycle(1'b0, 1'b0, 3'b111);
      checks++;
      if (wrap !== 1'b0 || binary !== 3'd0) begin
         errors++; $display("FAIL idle_after_wrap got wrap=%0b bin=%0d exp wrap=0 bin=0", wrap, binary);
      end
   endtask

   task automatic test_hold();
      cycle(1'b1, 1'b0, 3'b001);
      cycle(1'b1, 1'b0, 3'b011);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 3'b011);
         checks++;
         if (binary !== 3'd2 || locked !== 1'b1 || error !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d] got bin=%0d lock=%0b err=%0b wrap=%0b exp bin=2 lock=1 err=0 wrap=0",
                     i, binary, locked, error, wrap);
         end
      end
   endtask

   task automatic test_bad_step();
      cycle(1'b1, 1'b0, 3'b010);
      cycle(1'b1, 1'b0, 3'b111);
      checks++;
      if (error !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || binary !== 3'd5) begin
         errors++;
         $display("FAIL bad_step got err=%0b cnt=%0d lock=%0b bin=%0d exp err=1 cnt=1 lock=0 bin=5",
                  error, err_cnt, locked, binary);
      end
      cycle(1'b1, 1'b0, 3'b101);
      checks++;
      if (locked !== 1'b1 || error !== 1'b1 || binary !== 3'd6) begin
         errors++;
         $display("FAIL relock got lock=%0b err=%0b bin=%0d exp lock=1 err=1 bin=6", locked, error, binary);
      end
   endtask

   task automatic test_clear();
      cycle(1'b1, 1'b1, 3'b010);
      checks++;
      if ({binary, wrap, locked, error, err_cnt} !== '0) begin
         errors++;
         $display("FAIL clear got bin=%0d wrap=%0b lock=%0b err=%0b cnt=%0d exp all 0",
                  binary, wrap, locked, error, err_cnt);
      end
      cycle(1'b1, 1'b0, 3'b110);
      checks++;
      if (binary !== 3'd4 || locked !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL clear_capture got bin=%0d lock=%0b err=%0b exp bin=4 lock=0 err=0", binary, locked, error);
      end
      cycle(1'b1, 1'b0, 3'b111);
      checks++;
      if (locked !== 1'b1 || binary !== 3'd5) begin
         errors++; $display("FAIL clear_lock got lock=%0b bin=%0d exp lock=1 bin=5", locked, binary);
      end
   endtask

   task automatic test_saturation();
      logic [WIDTH-1:0] v;
      v = 3'd5;
      for (int i = 0; i < 300; i++) begin
         v = v + 3'd3;
         cycle(1'b1, 1'b0, b2g(v));
         v = v + 3'd1;
         cycle(1'b1, 1'b0, b2g(v));
         if (i == 9) begin
            checks++;
            if (err_cnt !== 8'd10) begin
               errors++; $display("FAIL sat_partial got %0d exp 10", err_cnt);
            end
         end
      end
      checks++;
      if (err_cnt !== 8'd255 || error !== 1'b1 || locked !== 1'b1) begin
         errors++;
         $display("FAIL saturation got cnt=%0d err=%0b lock=%0b exp cnt=255 err=1 lock=1", err_cnt, error, locked);
      end
   endtask

   task automatic test_async_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({binary, wrap, locked, error, err_cnt} !== '0) begin
         errors++;
         $display("FAIL async_reset got bin=%0d wrap=%0b lock=%0b err=%0b cnt=%0d exp all 0",
                  binary, wrap, locked, error, err_cnt);
      end
      model_reset();
      cycle(1'b1, 1'b0, 3'b011);
      #2 rst_n = 1'b1;
      cycle(1'b1, 1'b0, 3'b111);
      checks++;
      if (binary !== 3'd5 || locked !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_capture got bin=%0d lock=%0b err=%0b exp bin=5 lock=0 err=0",
                  binary, locked, error);
      end
      cycle(1'b1, 1'b0, 3'b101);
      checks++;
      if (binary !== 3'd6 || locked !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_lock got bin=%0d lock=%0b err=%0b exp bin=6 lock=1 err=0",
                  binary, locked, error);
      end
   endtask

   initial begin
      test_reset();
      test_count_sequence();
      test_hold();
      test_bad_step();
      test_clear();
      test_saturation();
      test_async_reset();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
- Receiving end of the Gray-code counter output bus.
- Samples a WIDTH-bit Gray code on each strobe, converts it to binary, and checks that successive codes form a legal +1 (or hold) sequence.
- Flags wrap-around and tracks step errors.
- Sits downstream of the Gray counter as a checker/decoder for status logic and self-test.

Parameters:
- WIDTH, 3, width of the Gray input and binary output.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- En  input  1  sample strobe; Gray is valid when En=1
- Clear  input  1  synchronous clear of status and state
- Gray  input  WIDTH  Gray-coded count from the upstream counter
- Output  output  WIDTH  registered binary decode of the last accepted sample
- Wrap  output  1  one-cycle pulse on a legal max->0 step while locked
- Locked  output  1  decoder is tracking a legal sequence
- Error  output  1  sticky flag: illegal step seen while locked
- ErrCnt  output  ERR_CNT_W  count of illegal steps, saturating at all-ones

Behaviour:
- Reset low, asynchronous:
  - state=IDLE; Output=0, Wrap=0, Locked=0, Error=0, ErrCnt=0; internal prev=0.
  - Takes effect immediately, including mid-sequence.
- Decode (combinational, internal):
  - dec[WIDTH-1]=Gray[WIDTH-1]
  - dec[i]=dec[i+1]^Gray[i] for i=WIDTH-2..0
- Latency:
  - Output updates on the Clk edge where En=1; visible the cycle after En.
  - Output holds when En=0.
- Step classification, with next=(prev+1) mod 2^WIDTH:
  - HOLD: dec==prev
  - STEP: dec==next
  - BAD: anything else
- Priority: Reset > Clear > En.
  - Clear=1: state=IDLE; Output, Wrap, Locked, Error, ErrCnt, prev all go to 0; a coincident En sample is dropped.
- Wrap defaults to 0 every cycle unless set below.
- FSM, evaluated only when En=1:
  - IDLE: prev<=dec, Output<=dec; go to ACQ.
  - ACQ:
    - STEP: go to LOCKED, Locked<=1.
    - HOLD or BAD: stay in ACQ.
    - Always prev<=dec, Output<=dec.
    - No errors are counted in ACQ.
  - LOCKED:
    - HOLD: no change.
    - STEP: prev<=dec, Output<=dec; Wrap<=1 if prev==2^WIDTH-1 and dec==0.
    - BAD: Error<=1; ErrCnt<=ErrCnt+1 unless all-ones; Locked<=0; go to ACQ; prev<=dec, Output<=dec.
- Error stays set until Clear or Reset.
- ErrCnt never wraps.
- En=0 in any state: no state or output change except Wrap returning to 0.

Test Plan:
- Reset low then high; En pulses with Gray 000,001,011,010,110,111,101,100,000:
  - Output 0,1,2,3,4,5,6,7,0.
  - Locked=1 from the cycle after the 001 sample.
  - Wrap=1 for exactly the cycle after the final 000 sample.
  - Error=0.
- Locked at Output=3 (Gray 010); next sample Gray 111 (dec 5):
  - Error=1, ErrCnt=1, Locked=0, Output=5.
  - Next sample 101 (dec 6) -> Locked=1, Error still 1.
- Hold check: while locked at Output=2, repeat Gray 011 for 4 En cycles -> Output stays 2, Locked=1, Error=0, Wrap=0.
- Saturation: inject 300 BAD steps, re-locking each time, with ERR_CNT_W=8 -> ErrCnt saturates at 255 and stays there.
- Clear and En asserted together while locked with Error=1 -> all outputs 0 the next cycle, state IDLE, sample ignored; the next En sample re-enters ACQ.
- Reset pulsed low mid-sequence between edges -> outputs go to 0 asynchronously without waiting for Clk.
  - After release, the first En sample is treated as the IDLE capture; no Error.
